lvt_read_stage: RTL and testbench
=================================

// Module: lvt_read_stage
// PURPOSE
//  Read-side back end of the LVT multi-port memory. Takes per-port read requests and
//  the one-cycle-late bank outputs and LVT port ids. Selects the bank last written for
//  that address and forwards same-cycle writes. Returns registered read data 2 cycles
//  after issue. Sits between the bank/LVT arrays and the consumers of each memory port.
// PARAMETERS
//  WIDTH  32  data word width in bits
//  DEPTH  64  words per bank; address width AW = $clog2(DEPTH)
//  PORTS  4   number of memory ports (>=2); id width IW = $clog2(PORTS)
// PORTS
//  clk      in   1                clock
//  rst      in   1                synchronous reset, active-high
//  rd_en    in   [PORTS] x 1      read request per port, cycle N
//  rd_addr  in   [PORTS] x AW     read address per port, cycle N
//  wr_en    in   [PORTS] x 1      snooped write enable, same cycle as bank writes
//  wr_addr  in   [PORTS] x AW     snooped write address
//  wr_d     in   [PORTS] x WIDTH  snooped write data
//  bank_q   in   [PORTS][PORTS] x WIDTH  bank_q[p][k]: port p view of bank written by k, valid N+1
//  lvt_q    in   [PORTS] x IW     LVT id of last writer for rd_addr[p], valid N+1
//  q_valid  out  [PORTS] x 1      one-cycle pulse, read data valid (cycle N+2)
//  q        out  [PORTS] x WIDTH  read data; holds last value when q_valid low
//  lvt_err  out  1                sticky: lvt_q id >= PORTS seen on a live read
// BEHAVIOUR
//  - Reset (rst=1 at posedge): q_valid=0, q=0, lvt_err=0, all pipeline valids=0.
//    An in-flight read is dropped; no q_valid for it after reset.
//  - Stage 1 (edge ending cycle N): register rd_en->v1, rd_addr->a1 per port.
//    Forward check against writes in cycle N: hit if wr_en[k] && wr_addr[k]==rd_addr[p].
//    Register fwd_hit1 and fwd_d1 = wr_d of the highest-index matching k.
//    This matches the LVT rule that the highest port wins a same-address collision.
//  - Stage 2 (edge ending cycle N+1): if v1[p]:
//    q[p] <= fwd_hit1 ? fwd_d1 : bank_q[p][lvt_q[p]]; q_valid[p] <= 1.
//    Otherwise q_valid[p] <= 0 and q[p] is held.
//  - Latency: exactly 2 cycles, rd_en at N -> q_valid at N+2. Throughput 1 read/port/cycle.
//  - Write semantics: a write in the same cycle as the read is visible (write-first).
//    A write in cycle N+1 is not visible; the read returns the pre-write value.
//  - Multiple writes to one address in cycle N: the highest k wins the forward.
//  - lvt_q[p] >= PORTS (non-power-of-2 PORTS) on a live stage-2 read: q[p] <= 0,
//    q_valid[p] <= 1, lvt_err <= 1 until reset.
//  - Ports are independent; one port's read never stalls or alters another port.
//  - rd_en high with an address already in flight is legal; each read returns in order.
// STRUCTURE
//  - lvt_pkg: localparams AW/IW helpers, typedef port_id_t, typedef addr_t (shared with
//    lvt_memory and xor_distributed_memory).
//  - Sub-module lvt_fwd_match: combinational per-read-port address compare across all
//    write ports; highest-index priority encode; outputs hit and data. Instanced PORTS
//    times inside a generate loop. Pipeline registers and the bank mux stay in the top module.
// TESTING
//  1 reset: rst=1 for 2 cycles while rd_en=all 1s -> q_valid=0, q=0, lvt_err=0 through
//    and 1 cycle after the rst release.
//  2 basic: p0 reads addr 5 at N, lvt_q[0]=2 and bank_q[0][2]=0xCAFE at N+1
//    -> q[0]=0xCAFE, q_valid[0]=1 at N+2 only.
//  3 forward: p1 writes 0x1234 to addr 9 while p0 reads addr 9 at N, bank holds 0xBEEF
//    -> q[0]=0x1234 at N+2. The same write at N+1 instead -> q[0]=0xBEEF.
//  4 collision: p1 and p3 both write addr 3 (0x11, 0x33) while p2 reads 3
//    -> q[2]=0x33.
//  5 back-to-back: p0 reads addr 1,2,3 on consecutive cycles -> three consecutive
//    q_valid pulses, data in order. rst asserted in the 2nd issue cycle -> no further pulses.
//  6 bad id (PORTS=3): lvt_q[0]=3 on a live read -> q[0]=0, lvt_err=1 and sticky until rst.

Source files
------------

// File: rtl/lvt_pkg.sv
// Shared LVT memory definitions: width helpers and default-sized address/port-id types.
package lvt_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 64;
  localparam int DEF_PORTS = 4;

  // Never collapse to a zero-width field for tiny depths or port counts.
  function automatic int addr_bits(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic int id_bits(input int ports);
    return (ports > 2) ? $clog2(ports) : 1;
  endfunction

  localparam int DEF_AW = addr_bits(DEF_DEPTH);
  localparam int DEF_IW = id_bits(DEF_PORTS);

  typedef logic [DEF_AW-1:0] addr_t;
  typedef logic [DEF_IW-1:0] port_id_t;

endpackage

// File: rtl/lvt_fwd_match.sv
// Same-cycle write forwarding for one read port: address compare against every
// write port, highest-index match wins to mirror the LVT collision rule.
module lvt_fwd_match
  import lvt_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW,
  parameter int PORTS = DEF_PORTS
) (
  input  logic [AW-1:0]          rd_addr,
  input  logic [PORTS-1:0]       wr_en,
  input  logic [PORTS*AW-1:0]    wr_addr,
  input  logic [PORTS*WIDTH-1:0] wr_d,
  output logic                   hit,
  output logic [WIDTH-1:0]       d
);

  // Ascending scan: a later (higher) port overrides any earlier match.
  always_comb begin
    hit = 1'b0;
    d   = '0;
    for (int k = 0; k < PORTS; k++) begin
      if (wr_en[k] && (wr_addr[k*AW +: AW] == rd_addr)) begin
        hit = 1'b1;
        d   = wr_d[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/lvt_read_stage.sv
// Read-side back end of the LVT multi-port memory: two-stage pipeline that
// forwards same-cycle writes, otherwise picks the bank named by the LVT.
module lvt_read_stage
  import lvt_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PORTS = DEF_PORTS,
  localparam int AW   = addr_bits(DEPTH),
  localparam int IW   = id_bits(PORTS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PORTS-1:0]             rd_en,
  input  logic [PORTS*AW-1:0]          rd_addr,
  input  logic [PORTS-1:0]             wr_en,
  input  logic [PORTS*AW-1:0]          wr_addr,
  input  logic [PORTS*WIDTH-1:0]       wr_d,
  input  logic [PORTS*PORTS*WIDTH-1:0] bank_q,
  input  logic [PORTS*IW-1:0]          lvt_q,
  output logic [PORTS-1:0]             q_valid,
  output logic [PORTS*WIDTH-1:0]       q,
  output logic                         lvt_err
);

  logic [PORTS-1:0] bad_live;
  logic             lvt_err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_port
      logic             fwd_hit;
      logic [WIDTH-1:0] fwd_d;
      logic             v1_reg;
      logic             hit1_reg;
      logic [WIDTH-1:0] d1_reg;
      logic             qv_reg;
      logic [WIDTH-1:0] q_reg;
      logic [IW-1:0]    id;
      logic [WIDTH-1:0] bank_sel;
      logic             bad;

      lvt_fwd_match #(
        .WIDTH (WIDTH),
        .AW    (AW),
        .PORTS (PORTS)
      ) u_fwd (
        .rd_addr (rd_addr[gi*AW +: AW]),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_d    (wr_d),
        .hit     (fwd_hit),
        .d       (fwd_d)
      );

      assign id = lvt_q[gi*IW +: IW];

      always_comb begin
        bank_sel = '0;
        for (int k = 0; k < PORTS; k++) begin
          if (id == IW'(k)) bank_sel = bank_q[(gi*PORTS + k)*WIDTH +: WIDTH];
        end
      end

      // Out-of-range ids only exist when PORTS is not a power of two.
      if (PORTS < (1 << IW)) begin : g_bad
        assign bad = (id > IW'(PORTS - 1));
      end else begin : g_nobad
        assign bad = 1'b0;
      end

      assign bad_live[gi] = v1_reg && bad;

      always_ff @(posedge clk) begin
        if (rst) begin
          v1_reg   <= 1'b0;
          hit1_reg <= 1'b0;
          d1_reg   <= '0;
          qv_reg   <= 1'b0;
          q_reg    <= '0;
        end else begin
          v1_reg   <= rd_en[gi];
          hit1_reg <= fwd_hit;
          d1_reg   <= fwd_d;
          qv_reg   <= v1_reg;
          if (v1_reg) q_reg <= bad ? '0 : (hit1_reg ? d1_reg : bank_sel);
        end
      end

      assign q_valid[gi]            = qv_reg;
      assign q[gi*WIDTH +: WIDTH]   = q_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)            lvt_err_reg <= 1'b0;
    else if (|bad_live) lvt_err_reg <= 1'b1;
  end

  assign lvt_err = lvt_err_reg;

endmodule

// File: tb/tb_lvt_read_stage.sv
// Scoreboard bench for lvt_read_stage: 4-port instance for data paths,
// 3-port instance for the out-of-range LVT id case.
module tb_lvt_read_stage;

  localparam int W   = 32;
  localparam int D   = 64;
  localparam int AW  = 6;
  localparam int PA  = 4;
  localparam int PB  = 3;
  localparam int IW  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [PA-1:0]       rd_en_a, wr_en_a, q_valid_a;
  logic [PA*AW-1:0]    rd_addr_a, wr_addr_a;
  logic [PA*W-1:0]     wr_d_a, q_a;
  logic [PA*PA*W-1:0]  bank_q_a;
  logic [PA*IW-1:0]    lvt_q_a;
  logic                lvt_err_a;

  logic [PB-1:0]       rd_en_b, wr_en_b, q_valid_b;
  logic [PB*AW-1:0]    rd_addr_b, wr_addr_b;
  logic [PB*W-1:0]     wr_d_b, q_b;
  logic [PB*PB*W-1:0]  bank_q_b;
  logic [PB*IW-1:0]    lvt_q_b;
  logic                lvt_err_b;

  lvt_read_stage #(.WIDTH(W), .DEPTH(D), .PORTS(PA)) dut_a (
    .clk(clk), .rst(rst), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_d(wr_d_a),
    .bank_q(bank_q_a), .lvt_q(lvt_q_a),
    .q_valid(q_valid_a), .q(q_a), .lvt_err(lvt_err_a)
  );

  lvt_read_stage #(.WIDTH(W), .DEPTH(D), .PORTS(PB)) dut_b (
    .clk(clk), .rst(rst), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_d(wr_d_b),
    .bank_q(bank_q_b), .lvt_q(lvt_q_b),
    .q_valid(q_valid_b), .q(q_b), .lvt_err(lvt_err_b)
  );

  typedef struct {
    int          inst;
    int          port;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push(input int inst, input int port, input logic [31:0] data);
    exp_t e;
    e.inst = inst;
    e.port = port;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic check_out(input int inst, input int port, input logic [31:0] data);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_valid: inst %0d port %0d data %h, required no pulse", inst, port, data);
    end else begin
      e = sb.pop_front();
      if (e.inst != inst || e.port != port || e.data !== data) begin
        n_err++;
        $display("FAIL read_data: got inst %0d port %0d data %h, required inst %0d port %0d data %h",
                 inst, port, data, e.inst, e.port, e.data);
      end else begin
        $display("read ok: inst %0d port %0d data %h", inst, port, data);
      end
    end
  endtask

  // Monitor: every q_valid pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    for (int p = 0; p < PA; p++)
      if (q_valid_a[p] === 1'b1) check_out(0, p, q_a[p*W +: W]);
    for (int p = 0; p < PB; p++)
      if (q_valid_b[p] === 1'b1) check_out(1, p, q_b[p*W +: W]);
  end

  task automatic clear_inputs();
    rd_en_a = '0; rd_addr_a = '0; wr_en_a = '0; wr_addr_a = '0; wr_d_a = '0;
    bank_q_a = '0; lvt_q_a = '0;
    rd_en_b = '0; rd_addr_b = '0; wr_en_b = '0; wr_addr_b = '0; wr_d_b = '0;
    bank_q_b = '0; lvt_q_b = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_a(input int p, input int addr);
    logic [31:0] a;
    a = addr;
    rd_en_a[p] = 1'b1;
    rd_addr_a[p*AW +: AW] = a[AW-1:0];
  endtask

  task automatic wr_a(input int k, input int addr, input logic [31:0] d);
    logic [31:0] a;
    a = addr;
    wr_en_a[k] = 1'b1;
    wr_addr_a[k*AW +: AW] = a[AW-1:0];
    wr_d_a[k*W +: W] = d;
  endtask

  // Selected bank carries v; every other bank carries a distinct decoy.
  task automatic bank_a(input int p, input int id, input logic [31:0] v);
    logic [31:0] i;
    i = id;
    for (int k = 0; k < PA; k++)
      bank_q_a[(p*PA + k)*W +: W] = (k == id) ? v : (32'hD000_0000 | (p << 8) | k);
    lvt_q_a[p*IW +: IW] = i[IW-1:0];
  endtask

  task automatic bank_b(input int p, input int id, input logic [31:0] v);
    logic [31:0] i;
    i = id;
    for (int k = 0; k < PB; k++)
      bank_q_b[(p*PB + k)*W +: W] = (k == id) ? v : (32'hB000_0000 | (p << 8) | k);
    lvt_q_b[p*IW +: IW] = i[IW-1:0];
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    rd_en_a = '1;
    rd_en_b = '1;

    // 1 reset with reads requested
    step();
    step();
    chk("rst_qvalid_a", {28'd0, q_valid_a}, 32'd0);
    chk("rst_q_a0", q_a[31:0], 32'd0);
    chk("rst_lvt_err_a", {31'd0, lvt_err_a}, 32'd0);
    chk("rst_qvalid_b", {29'd0, q_valid_b}, 32'd0);
    chk("rst_lvt_err_b", {31'd0, lvt_err_b}, 32'd0);
    rst = 1'b0;
    clear_inputs();
    step();
    chk("post_rst_qvalid_a", {28'd0, q_valid_a}, 32'd0);
    chk("post_rst_qvalid_b", {29'd0, q_valid_b}, 32'd0);
    step();

    // 2 basic bank select via LVT id
    clear_inputs(); rd_a(0, 5); push(0, 0, 32'h0000CAFE);
    step();
    clear_inputs(); bank_a(0, 2, 32'h0000CAFE);
    chk("basic_not_early", {31'd0, q_valid_a[0]}, 32'd0);
    step();
    clear_inputs();
    step();
    chk("basic_single_pulse", {31'd0, q_valid_a[0]}, 32'd0);
    chk("basic_hold", q_a[31:0], 32'h0000CAFE);

    // 3 forward: same-cycle write visible, unrelated address ignored
    clear_inputs(); rd_a(0, 9); wr_a(1, 9, 32'h1234); wr_a(2, 8, 32'h5555);
    push(0, 0, 32'h00001234);
    step();
    clear_inputs(); bank_a(0, 1, 32'h0000BEEF);
    step();
    // write one cycle late is not visible
    clear_inputs(); rd_a(0, 9); push(0, 0, 32'h0000BEEF);
    step();
    clear_inputs(); bank_a(0, 1, 32'h0000BEEF); wr_a(1, 9, 32'h1234);
    step();
    clear_inputs();
    step();

    // 4 collision: highest write port wins
    clear_inputs(); rd_a(2, 3); wr_a(1, 3, 32'h11); wr_a(3, 3, 32'h33);
    push(0, 2, 32'h00000033);
    step();
    clear_inputs(); bank_a(2, 3, 32'h99);
    step();
    clear_inputs();
    step();

    // independent ports in the same cycle
    clear_inputs(); rd_a(0, 7); rd_a(3, 8);
    push(0, 0, 32'hA0A0_0007); push(0, 3, 32'hA3A3_0008);
    step();
    clear_inputs(); bank_a(0, 3, 32'hA0A0_0007); bank_a(3, 0, 32'hA3A3_0008);
    step();
    clear_inputs();
    step();
    chk("indep_hold_p1", q_a[1*W +: W], 32'd0);

    // 5 back-to-back reads on port 0
    clear_inputs(); rd_a(0, 1); push(0, 0, 32'h101);
    step();
    clear_inputs(); rd_a(0, 2); push(0, 0, 32'h102); bank_a(0, 0, 32'h101);
    step();
    clear_inputs(); rd_a(0, 3); push(0, 0, 32'h103); bank_a(0, 3, 32'h102);
    step();
    clear_inputs(); bank_a(0, 1, 32'h103);
    step();
    clear_inputs();
    step();
    step();
    // reset during the second issue cycle drops everything in flight
    clear_inputs(); rd_a(0, 1);
    step();
    clear_inputs(); rd_a(0, 2); bank_a(0, 0, 32'h201); rst = 1'b1;
    step();
    rst = 1'b0;
    clear_inputs();
    chk("rst_drop_q", q_a[31:0], 32'd0);
    step();
    step();
    step();
    chk("rst_drop_qvalid", {28'd0, q_valid_a}, 32'd0);

    // 6 bad LVT id on the 3-port instance
    clear_inputs(); bank_b(2, 3, 32'h1);
    step();
    clear_inputs();
    step();
    chk("idle_bad_id_no_err", {31'd0, lvt_err_b}, 32'd0);
    clear_inputs(); rd_en_b[0] = 1'b1; rd_addr_b[5:0] = 6'd4; push(1, 0, 32'd0);
    step();
    clear_inputs(); bank_b(0, 3, 32'hFFFF_FFFF); bank_b(0, 2, 32'hFFFF_FFFF);
    lvt_q_b[1:0] = 2'd3;
    chk("err_not_early", {31'd0, lvt_err_b}, 32'd0);
    step();
    clear_inputs();
    chk("bad_id_err", {31'd0, lvt_err_b}, 32'd1);
    rd_en_b[1] = 1'b1; rd_addr_b[11:6] = 6'd2; push(1, 1, 32'h77);
    step();
    clear_inputs(); bank_b(1, 2, 32'h77);
    step();
    clear_inputs();
    step();
    step();
    chk("err_sticky", {31'd0, lvt_err_b}, 32'd1);
    chk("err_a_clean", {31'd0, lvt_err_a}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("err_cleared", {31'd0, lvt_err_b}, 32'd0);
    step();
    step();

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
